// File: rtl/error_controller.sv
// rtl/error_controller.sv - backward-pass sequencer feeding delta vectors to the backprop datapath
// Optional macro ERROR_CTRL_SATURATE_EN: clamp hidden-layer lanes instead of wrapping them.
module error_controller #(
  parameter int NEURON_NUM       = 5,
  parameter int ERROR_WIDTH      = 10,
  parameter int DELTA_WIDTH      = 9,
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int LAYER_MAX        = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NEURON_NUM*DELTA_WIDTH-1:0] start_errors,
  input  logic                              start_errors_valid,
  output logic                              start_errors_ready,
  input  logic [LAYER_ADDR_WIDTH-1:0]       layer_number,
  input  logic                              layer_number_valid,
  output logic                              layer_number_ready,
  input  logic [NEURON_NUM*ERROR_WIDTH-1:0] prop_errors,
  input  logic                              prop_errors_valid,
  output logic                              prop_errors_ready,
  output logic [NEURON_NUM*DELTA_WIDTH-1:0] delta_inputs,
  output logic                              delta_inputs_valid,
  input  logic                              delta_inputs_ready,
  output logic                              layer_error,
  output logic                              pass_done
);

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_PROP, SEND} state_t;

  localparam logic [LAYER_ADDR_WIDTH-1:0] LAST_LAYER = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);

  state_t                              state_q, state_d;
  logic [LAYER_ADDR_WIDTH-1:0]         expected_layer_q, expected_layer_d;
  logic [LAYER_ADDR_WIDTH-1:0]         cur_layer_q, cur_layer_d;
  logic [NEURON_NUM*DELTA_WIDTH-1:0]   delta_buf_q, delta_buf_d;
  logic                                layer_error_q, layer_error_d;
  logic                                pass_done_q, pass_done_d;
  logic [NEURON_NUM*DELTA_WIDTH-1:0]   narrow_vec;
  logic signed [ERROR_WIDTH-1:0]       lane;

`ifdef ERROR_CTRL_SATURATE_EN
  localparam logic signed [ERROR_WIDTH-1:0] SAT_MAX = ERROR_WIDTH'((2 ** (DELTA_WIDTH - 1)) - 1);
  localparam logic signed [ERROR_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    narrow_vec = '0;
    lane       = '0;
    for (int i = 0; i < NEURON_NUM; i++) begin
      lane = prop_errors[i*ERROR_WIDTH +: ERROR_WIDTH];
      if (lane > SAT_MAX)
        narrow_vec[i*DELTA_WIDTH +: DELTA_WIDTH] = SAT_MAX[DELTA_WIDTH-1:0];
      else if (lane < SAT_MIN)
        narrow_vec[i*DELTA_WIDTH +: DELTA_WIDTH] = SAT_MIN[DELTA_WIDTH-1:0];
      else
        narrow_vec[i*DELTA_WIDTH +: DELTA_WIDTH] = lane[DELTA_WIDTH-1:0];
    end
  end
`else
  logic unused_hi_bits;

  // Wrap mode keeps only the low bits; the discarded high bits are folded into a sink.
  always_comb begin
    narrow_vec     = '0;
    lane           = '0;
    unused_hi_bits = 1'b0;
    for (int i = 0; i < NEURON_NUM; i++) begin
      lane = prop_errors[i*ERROR_WIDTH +: ERROR_WIDTH];
      narrow_vec[i*DELTA_WIDTH +: DELTA_WIDTH] = lane[DELTA_WIDTH-1:0];
      unused_hi_bits = unused_hi_bits ^ (^lane[ERROR_WIDTH-1:DELTA_WIDTH]);
    end
  end
`endif

  assign layer_number_ready = !rst && (state_q == IDLE);
  assign start_errors_ready = !rst && (state_q == WAIT_START);
  assign prop_errors_ready  = !rst && (state_q == WAIT_PROP);
  assign delta_inputs_valid = !rst && (state_q == SEND);
  assign delta_inputs       = delta_buf_q;
  assign layer_error        = layer_error_q;
  assign pass_done          = pass_done_q;

  always_comb begin
    state_d          = state_q;
    expected_layer_d = expected_layer_q;
    cur_layer_d      = cur_layer_q;
    delta_buf_d      = delta_buf_q;
    layer_error_d    = 1'b0;
    pass_done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (layer_number_valid) begin
          if (layer_number == expected_layer_q) begin
            cur_layer_d = layer_number;
            state_d     = (layer_number == LAST_LAYER) ? WAIT_START : WAIT_PROP;
          end else begin
            layer_error_d = 1'b1;
          end
        end
      end
      WAIT_START: begin
        if (start_errors_valid) begin
          delta_buf_d = start_errors;
          state_d     = SEND;
        end
      end
      WAIT_PROP: begin
        if (prop_errors_valid) begin
          delta_buf_d = narrow_vec;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (delta_inputs_ready) begin
          state_d = IDLE;
          // Layer 1 closes the pass; the next pass restarts at the output layer.
          if (cur_layer_q > LAYER_ADDR_WIDTH'(1)) begin
            expected_layer_d = cur_layer_q - LAYER_ADDR_WIDTH'(1);
          end else begin
            expected_layer_d = LAST_LAYER;
            pass_done_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      expected_layer_q <= LAST_LAYER;
      cur_layer_q      <= '0;
      delta_buf_q      <= '0;
      layer_error_q    <= 1'b0;
      pass_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      expected_layer_q <= expected_layer_d;
      cur_layer_q      <= cur_layer_d;
      delta_buf_q      <= delta_buf_d;
      layer_error_q    <= layer_error_d;
      pass_done_q      <= pass_done_d;
    end
  end

endmodule

// File: tb/tb_error_controller.sv
// tb/tb_error_controller.sv - directed self-checking bench for error_controller
module tb_error_controller;

  localparam int NN = 5;
  localparam int EW = 10;
  localparam int DW = 9;
  localparam int LW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NN*DW-1:0]   start_errors;
  logic               start_errors_valid;
  logic               start_errors_ready;
  logic [LW-1:0]      layer_number;
  logic               layer_number_valid;
  logic               layer_number_ready;
  logic [NN*EW-1:0]   prop_errors;
  logic               prop_errors_valid;
  logic               prop_errors_ready;
  logic [NN*DW-1:0]   delta_inputs;
  logic               delta_inputs_valid;
  logic               delta_inputs_ready;
  logic               layer_error;
  logic               pass_done;

  int errors = 0;
  int checks = 0;
  int pd_cnt = 0;
  int d_cnt  = 0;

  logic [NN*DW-1:0] vec_a;
  logic [NN*DW-1:0] exp_d;
  logic [NN*DW-1:0] held;

  error_controller #(
    .NEURON_NUM(NN), .ERROR_WIDTH(EW), .DELTA_WIDTH(DW),
    .LAYER_ADDR_WIDTH(LW), .LAYER_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .start_errors(start_errors), .start_errors_valid(start_errors_valid),
    .start_errors_ready(start_errors_ready),
    .layer_number(layer_number), .layer_number_valid(layer_number_valid),
    .layer_number_ready(layer_number_ready),
    .prop_errors(prop_errors), .prop_errors_valid(prop_errors_valid),
    .prop_errors_ready(prop_errors_ready),
    .delta_inputs(delta_inputs), .delta_inputs_valid(delta_inputs_valid),
    .delta_inputs_ready(delta_inputs_ready),
    .layer_error(layer_error), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Sample one time unit after the edge; also tallies pulses and delta transfers.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pass_done === 1'b1) pd_cnt++;
    if (delta_inputs_valid === 1'b1 && delta_inputs_ready === 1'b1) d_cnt++;
  endtask

  task automatic send_layer(input logic [LW-1:0] n);
    layer_number       = n;
    layer_number_valid = 1'b1;
    tick();
    layer_number_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start_errors = '0; start_errors_valid = 1'b0;
    layer_number = '0; layer_number_valid = 1'b0;
    prop_errors = '0;  prop_errors_valid = 1'b0;
    delta_inputs_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_lnr", 64'(layer_number_ready), 64'd0);
    check("rst_ser", 64'(start_errors_ready), 64'd0);
    check("rst_per", 64'(prop_errors_ready), 64'd0);
    check("rst_dv", 64'(delta_inputs_valid), 64'd0);
    check("rst_d", 64'(delta_inputs), 64'd0);
    check("rst_le", 64'(layer_error), 64'd0);
    check("rst_pd", 64'(pass_done), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_lnr", 64'(layer_number_ready), 64'd1);

    // Output layer from start errors, then hold under backpressure
    send_layer(2'd2);
    check("l2_ser", 64'(start_errors_ready), 64'd1);
    check("l2_lnr", 64'(layer_number_ready), 64'd0);
    vec_a = {9'd5, 9'd4, 9'd3, 9'd2, 9'd1};
    start_errors = vec_a;
    start_errors_valid = 1'b1;
    tick();
    start_errors_valid = 1'b0;
    check("start_dv", 64'(delta_inputs_valid), 64'd1);
    check("start_d", 64'(delta_inputs), 64'(vec_a));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_dv", 64'(delta_inputs_valid), 64'd1);
      check("hold_d", 64'(delta_inputs), 64'(vec_a));
    end
    delta_inputs_ready = 1'b1;
    tick();
    delta_inputs_ready = 1'b0;
    check("acc2_dv", 64'(delta_inputs_valid), 64'd0);
    check("acc2_lnr", 64'(layer_number_ready), 64'd1);
    check("acc2_pd", 64'(pass_done), 64'd0);

    // Hidden layer: start errors must be ignored while waiting for prop errors
    send_layer(2'd1);
    check("l1_per", 64'(prop_errors_ready), 64'd1);
    start_errors = {9'd9, 9'd9, 9'd9, 9'd9, 9'd9};
    start_errors_valid = 1'b1;
    tick();
    check("wp_ser", 64'(start_errors_ready), 64'd0);
    check("wp_dv", 64'(delta_inputs_valid), 64'd0);
    tick();
    check("wp_ser2", 64'(start_errors_ready), 64'd0);
    check("wp_dv2", 64'(delta_inputs_valid), 64'd0);
    start_errors_valid = 1'b0;
    prop_errors[0*EW +: EW] = 10'sd300;
    prop_errors[1*EW +: EW] = -10'sd300;
    prop_errors[2*EW +: EW] = 10'sd100;
    prop_errors[3*EW +: EW] = -10'sd1;
    prop_errors[4*EW +: EW] = 10'sd0;
`ifdef ERROR_CTRL_SATURATE_EN
    exp_d[0*DW +: DW] = 9'h0FF;
    exp_d[1*DW +: DW] = 9'h100;
`else
    exp_d[0*DW +: DW] = 9'h12C;
    exp_d[1*DW +: DW] = 9'h0D4;
`endif
    exp_d[2*DW +: DW] = 9'd100;
    exp_d[3*DW +: DW] = 9'h1FF;
    exp_d[4*DW +: DW] = 9'd0;
    prop_errors_valid = 1'b1;
    tick();
    prop_errors_valid = 1'b0;
    check("prop_dv", 64'(delta_inputs_valid), 64'd1);
    check("prop_d", 64'(delta_inputs), 64'(exp_d));
    delta_inputs_ready = 1'b1;
    tick();
    delta_inputs_ready = 1'b0;
    check("pd_pulse", 64'(pass_done), 64'd1);
    tick();
    check("pd_clear", 64'(pass_done), 64'd0);
    // Expected layer has returned to 2: layer 1 is rejected, layer 2 accepted
    send_layer(2'd1);
    check("post_le", 64'(layer_error), 64'd1);
    tick();
    check("post_le_clr", 64'(layer_error), 64'd0);
    send_layer(2'd2);
    check("post_l2_ser", 64'(start_errors_ready), 64'd1);

    // Out-of-order layer numbers from reset
    do_reset();
    send_layer(2'd1);
    check("ooo1_le", 64'(layer_error), 64'd1);
    check("ooo1_lnr", 64'(layer_number_ready), 64'd1);
    tick();
    check("ooo1_le_clr", 64'(layer_error), 64'd0);
    send_layer(2'd3);
    check("ooo3_le", 64'(layer_error), 64'd1);
    tick();
    check("ooo3_le_clr", 64'(layer_error), 64'd0);
    send_layer(2'd0);
    check("ooo0_le", 64'(layer_error), 64'd1);
    send_layer(2'd2);
    check("ooo_l2_ser", 64'(start_errors_ready), 64'd1);
    check("ooo_l2_le", 64'(layer_error), 64'd0);

    // Reset while holding a delta in SEND
    start_errors = {9'd1, 9'd1, 9'd1, 9'd1, 9'd7};
    start_errors_valid = 1'b1;
    tick();
    start_errors_valid = 1'b0;
    check("send_dv", 64'(delta_inputs_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("rsend_dv", 64'(delta_inputs_valid), 64'd0);
    check("rsend_d", 64'(delta_inputs), 64'd0);
    rst = 1'b0;
    tick();
    send_layer(2'd1);
    check("rsend_le", 64'(layer_error), 64'd1);
    tick();

    // Two back-to-back passes with the sink always ready
    delta_inputs_ready = 1'b1;
    pd_cnt = 0;
    d_cnt  = 0;
    for (int p = 0; p < 2; p++) begin
      send_layer(2'd2);
      held = {9'd20, 9'd19, 9'd18, 9'd17, 9'd16} + 45'(p);
      start_errors = held;
      start_errors_valid = 1'b1;
      tick();
      start_errors_valid = 1'b0;
      check("b2b_start_d", 64'(delta_inputs), 64'(held));
      tick();
      send_layer(2'd1);
      for (int i = 0; i < NN; i++) begin
        prop_errors[i*EW +: EW] = 10'(i + 2 * p) - 10'sd3;
        exp_d[i*DW +: DW] = 9'(i + 2 * p) - 9'sd3;
      end
      prop_errors_valid = 1'b1;
      tick();
      prop_errors_valid = 1'b0;
      check("b2b_prop_d", 64'(delta_inputs), 64'(exp_d));
      tick();
    end
    tick();
    delta_inputs_ready = 1'b0;
    check("b2b_pass_cnt", 64'(pd_cnt), 64'd2);
    check("b2b_delta_cnt", 64'(d_cnt), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/error_controller.md
# error_controller

Backward-pass counterpart of `layer_controller`. It sequences error vectors through the shared backpropagation datapath from the output layer down to layer 1. For the output layer it takes the externally computed output error vector. For each hidden layer it takes the propagated error sums returned by the datapath, narrows them to delta width, and hands them back as the next delta input. It also checks that layer numbers arrive in strictly descending order.

## Interface
Parameters:
- `NEURON_NUM`, 5, neurons per layer (vector lanes).
- `ERROR_WIDTH`, 10, signed width of one propagated error sum.
- `DELTA_WIDTH`, 9, signed width of one delta lane.
- `LAYER_ADDR_WIDTH`, 2, width of layer number.
- `LAYER_MAX`, 3, number of layers; the output layer is `LAYER_MAX-1`.

Ports:
- `clk` in 1: clock; one clock domain.
- `rst` in 1: reset; synchronous, active-high.
- `start_errors` in NEURON_NUM*DELTA_WIDTH: output-layer error vector.
- `start_errors_valid` in 1; `start_errors_ready` out 1.
- `layer_number` in LAYER_ADDR_WIDTH: layer currently being backpropagated.
- `layer_number_valid` in 1; `layer_number_ready` out 1.
- `prop_errors` in NEURON_NUM*ERROR_WIDTH: propagated error sums from the datapath.
- `prop_errors_valid` in 1; `prop_errors_ready` out 1.
- `delta_inputs` out NEURON_NUM*DELTA_WIDTH: delta vector to the datapath.
- `delta_inputs_valid` out 1; `delta_inputs_ready` in 1.
- `layer_error` out 1: one-cycle pulse on an out-of-order layer number.
- `pass_done` out 1: one-cycle pulse when the layer-1 delta is accepted.

## Operation
- Handshake: a transfer occurs on a rising edge where valid && ready. Readies are functions of state only, never of any valid. All readies are 0 while `rst` is high.
- Registers:
  - `state`.
  - `expected_layer`; reset value LAYER_MAX-1.
  - `cur_layer`.
  - `delta_buf`; reset value 0.
- States:
  - IDLE: `layer_number_ready`=1.
    - Accepted number == `expected_layer`: latch into `cur_layer`. Go to WAIT_START if it equals LAYER_MAX-1, otherwise WAIT_PROP.
    - Accepted number != `expected_layer`: drop it, pulse `layer_error` the next cycle, stay in IDLE. Numbers 0 and ≥LAYER_MAX always mismatch.
  - WAIT_START: `start_errors_ready`=1. On transfer, copy `start_errors` into `delta_buf` and go to SEND.
  - WAIT_PROP: `prop_errors_ready`=1. On transfer, narrow each lane from ERROR_WIDTH to DELTA_WIDTH into `delta_buf` and go to SEND.
  - SEND: `delta_inputs_valid`=1 and `delta_inputs`=`delta_buf`. On transfer, go to IDLE and update `expected_layer`:
    - `cur_layer`>1: `expected_layer` ← `cur_layer`−1.
    - `cur_layer`==1: `expected_layer` ← LAYER_MAX−1 and pulse `pass_done` the next cycle.
- Lane i occupies bits [(i+1)*W−1 : i*W] in every vector.
- Narrowing is defined under Configuration.
- Inputs whose ready is 0 are ignored. This covers valid data offered in the wrong state, including start errors offered while a hidden layer is pending.
- `delta_inputs` holds stable while valid is high.

## Timing
- Reset values: `delta_inputs_valid`=0, `delta_inputs`=0, `layer_error`=0, `pass_done`=0, every ready=0. State is IDLE the cycle after `rst` deasserts.
- `layer_number` transfer at edge N → data ready high in cycle N+1.
- Data transfer at edge M → `delta_inputs_valid` high in cycle M+1. Minimum latency from layer number to delta valid is 2 cycles.
- Delta transfer at edge K → `layer_number_ready` high in cycle K+1; back-to-back layers are therefore possible.
- `layer_error` and `pass_done` are registered single-cycle pulses.
- `rst` asserted mid-operation (any state): the next edge forces IDLE, clears `delta_buf`, and resets `expected_layer` to LAYER_MAX−1. Any held delta is discarded.

## Configuration
- `ERROR_CTRL_SATURATE_EN` defined: each lane is clamped to the signed range [−2^(DELTA_WIDTH−1), 2^(DELTA_WIDTH−1)−1] (defaults: −256..255).
- Not defined: each lane takes the low DELTA_WIDTH bits, with wrap-around.
- Start errors are never narrowed in either build.

## Test plan
- Reset, then `layer_number`=2 → `start_errors_ready`=1 next cycle. Start `{9'd5,9'd4,9'd3,9'd2,9'd1}` → `delta_inputs` equals it and is valid one cycle later. Hold `delta_inputs_ready`=0 for 5 cycles → value and valid stay stable.
- Continue with `layer_number`=1 and `prop_errors` lanes {300, −300, 100, −1, 0}. With the macro defined → deltas {255, −256, 100, −1, 0}. With the macro undefined → {−212, 212, 100, −1, 0}. Accept the delta → `pass_done` pulses once and `expected_layer` returns to 2.
- From reset, `layer_number`=1 → `layer_error` pulses for one cycle, state stays IDLE, then `layer_number`=2 is accepted normally. Repeat with `layer_number`=3 → `layer_error` pulses.
- In WAIT_PROP with `start_errors_valid`=1 → `start_errors_ready` stays 0 and `delta_inputs_valid` stays 0 until `prop_errors_valid` arrives.
- `rst` pulsed while in SEND → `delta_inputs_valid`=0 next cycle, and `layer_number`=1 is then rejected with `layer_error`.
- Two full passes back-to-back with `delta_inputs_ready` tied high → `pass_done` pulses exactly twice, with no lost or duplicated deltas.
